// File: rtl/wb2reg_pkg.sv
// Shared types and defaults for the Wishbone-to-register-bus bridge.
package wb2reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam int unsigned TIMEOUT_CYC_DEF = 255;
  localparam int unsigned TIMER_W         = $clog2(TIMEOUT_CYC_DEF + 1);
  localparam logic [31:0] ERR_RDATA_DEF   = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb2reg_bridge_if.sv
// Wishbone slave side plus register-bus initiator side of the bridge.
interface wb2reg_bridge_if;

  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [5:0]  wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        wbs_err_o;

  logic        reg_cs;
  logic        reg_wr;
  logic [3:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_be;
  logic [31:0] reg_rdata;
  logic        reg_ack;

  // The bridge itself: Wishbone slave, register-bus initiator.
  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    output wbs_dat_o, wbs_ack_o, wbs_err_o,
    output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
    input  reg_rdata, reg_ack
  );

  // The environment: Wishbone master and register responder.
  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o,
    input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
    output reg_rdata, reg_ack
  );

endinterface

// File: rtl/wb2reg_bridge.sv
// Converts one Wishbone-classic access into one register-bus transfer,
// completing with ack, or with err when the register block never answers.
module wb2reg_bridge
  import wb2reg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter logic [31:0] ERR_RDATA   = ERR_RDATA_DEF
) (
  input  logic            mclk,
  input  logic            h_reset_n,
  wb2reg_bridge_if.slave  bus,
  output logic [7:0]      timeout_cnt
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          cs_q, cs_d;
  logic          wr_q, wr_d;
  logic [3:0]    addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [7:0]    tocnt_q, tocnt_d;

  // Byte-lane bits of the address carry no meaning on a word-wide register bus.
  logic unused_adr_bits;
  assign unused_adr_bits = ^bus.wbs_adr_i[1:0];

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cs_d    = cs_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    tocnt_d = tocnt_q;

    unique case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
          wr_d    = bus.wbs_we_i;
          addr_d  = bus.wbs_adr_i[5:2];
          wdata_d = bus.wbs_dat_i;
          be_d    = bus.wbs_sel_i;
          cs_d    = 1'b1;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // An ack arriving on the final timer cycle still counts as success.
        if (bus.reg_ack) begin
          cs_d    = 1'b0;
          rdata_d = wr_q ? 32'h0 : bus.reg_rdata;
          if (bus.wbs_cyc_i) begin
            ack_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (timer_q == TIMER_LAST) begin
          cs_d    = 1'b0;
          rdata_d = ERR_RDATA;
          if (tocnt_q != 8'hFF) begin
            tocnt_d = tocnt_q + 8'd1;
          end
          if (bus.wbs_cyc_i) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_RESP:  state_d = ST_DRAIN;
      // Swallows the edge where the finished access may still show stb.
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 4'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      rdata_q <= 32'h0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      tocnt_q <= 8'h0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      tocnt_q <= tocnt_d;
    end
  end

  assign bus.reg_cs    = cs_q;
  assign bus.reg_wr    = wr_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_be    = be_q;
  assign bus.wbs_dat_o = rdata_q;
  assign bus.wbs_ack_o = ack_q;
  assign bus.wbs_err_o = err_q;
  assign timeout_cnt   = tocnt_q;

endmodule

// File: tb/tb_wb2reg_bridge.sv
// Directed checks of the Wishbone-to-register-bus bridge with a 16-cycle timeout.
module tb_wb2reg_bridge;

  localparam int TO = 16;

  logic       mclk;
  logic       h_reset_n;
  logic [7:0] timeout_cnt;

  wb2reg_bridge_if bus();

  wb2reg_bridge #(
    .TIMEOUT_CYC (TO),
    .ERR_RDATA   (32'hDEAD_BEEF)
  ) dut (
    .mclk        (mclk),
    .h_reset_n   (h_reset_n),
    .bus         (bus),
    .timeout_cnt (timeout_cnt)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  int n_checks = 0;
  int n_errors = 0;

  // Results of the most recent run_xfer call.
  int          r_cs_cycles;
  int          r_ack_cnt;
  int          r_err_cnt;
  int          r_resp_cyc;
  logic [31:0] r_dat;
  logic        r_wr;
  logic [3:0]  r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_unstable;
  logic        r_both;

  int          exp_to;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  // One Wishbone access. Cycle 0 is the edge where stb is first sampled;
  // reg_ack is presented for the edge ending cycle ack_at (-1: never);
  // cyc/stb go low from cycle drop_at (-1: never); after a response the
  // master keeps stb up for hold more edges.
  task automatic run_xfer(input string name, input logic we, input logic [5:0] adr,
                          input logic [31:0] wdat, input logic [3:0] sel,
                          input int ack_at, input int drop_at, input int hold,
                          input logic [31:0] rdata);
    bit   done;
    bit   first;
    int   done_c;
    logic active;
    done = 0; first = 1; done_c = 0;
    r_cs_cycles = 0; r_ack_cnt = 0; r_err_cnt = 0; r_resp_cyc = -1;
    r_dat = 'x; r_wr = 0; r_addr = 0; r_wdata = 0; r_be = 0;
    r_unstable = 0; r_both = 0;
    for (int c = 0; c < TO + 8; c++) begin
      active = ((drop_at < 0) || (c < drop_at)) && (!done || (c < done_c + hold));
      bus.wbs_cyc_i = active;
      bus.wbs_stb_i = active;
      bus.wbs_we_i  = we;
      bus.wbs_adr_i = adr;
      bus.wbs_dat_i = wdat;
      bus.wbs_sel_i = sel;
      bus.reg_ack   = (c == ack_at);
      bus.reg_rdata = rdata;
      tick();
      if (bus.reg_cs) begin
        r_cs_cycles++;
        if (first) begin
          first   = 0;
          r_wr    = bus.reg_wr;
          r_addr  = bus.reg_addr;
          r_wdata = bus.reg_wdata;
          r_be    = bus.reg_be;
        end else if (bus.reg_wr !== r_wr || bus.reg_addr !== r_addr ||
                     bus.reg_wdata !== r_wdata || bus.reg_be !== r_be) begin
          r_unstable = 1;
        end
      end
      if (bus.wbs_ack_o && bus.wbs_err_o) r_both = 1;
      if (bus.wbs_ack_o) r_ack_cnt++;
      if (bus.wbs_err_o) r_err_cnt++;
      if ((bus.wbs_ack_o || bus.wbs_err_o) && !done) begin
        done       = 1;
        done_c     = c + 1;
        r_resp_cyc = c + 1;
        r_dat      = bus.wbs_dat_o;
      end
    end
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.reg_ack   = 1'b0;
    $display("xfer %-10s we=%0d adr=%h cs_cycles=%0d ack=%0d err=%0d resp_cyc=%0d dat=%h tocnt=%0d",
             name, we, adr, r_cs_cycles, r_ack_cnt, r_err_cnt, r_resp_cyc, r_dat, timeout_cnt);
  endtask

  task automatic check_xfer(input string tag, input int cs_cyc, input int acks, input int errs,
                            input int resp_cyc, input logic [31:0] dat);
    check({tag, "_cs_cycles"}, r_cs_cycles, cs_cyc);
    check({tag, "_ack_cnt"},   r_ack_cnt,   acks);
    check({tag, "_err_cnt"},   r_err_cnt,   errs);
    check({tag, "_resp_cyc"},  r_resp_cyc,  resp_cyc);
    check({tag, "_stable"},    r_unstable,  0);
    check({tag, "_ack_err"},   r_both,      0);
    if (resp_cyc >= 0) check({tag, "_dat"}, r_dat, dat);
  endtask

  int seen_ack;
  int seen_err;
  int seen_cs;

  initial begin
    h_reset_n     = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_adr_i = 6'h0;
    bus.wbs_dat_i = 32'h0;
    bus.wbs_sel_i = 4'h0;
    bus.reg_rdata = 32'h0;
    bus.reg_ack   = 1'b0;
    exp_to        = 0;

    tick(); tick();
    check("rst_cs",    bus.reg_cs,    0);
    check("rst_wr",    bus.reg_wr,    0);
    check("rst_addr",  bus.reg_addr,  0);
    check("rst_wdata", bus.reg_wdata, 0);
    check("rst_be",    bus.reg_be,    0);
    check("rst_dat",   bus.wbs_dat_o, 0);
    check("rst_ack",   bus.wbs_ack_o, 0);
    check("rst_err",   bus.wbs_err_o, 0);
    check("rst_tocnt", timeout_cnt,   0);
    @(negedge mclk);
    h_reset_n = 1'b1;
    tick();

    // Write, responder acks 2 cycles after cs: cs cycles 1..3, ack at 4.
    run_xfer("write", 1'b1, 6'h08, 32'hA5A5_0F0F, 4'hC, 3, -1, 1, 32'h0);
    check_xfer("wr", 3, 1, 0, 4, 32'h0);
    check("wr_reg_wr",    r_wr,    1);
    check("wr_reg_addr",  r_addr,  4'h2);
    check("wr_reg_wdata", r_wdata, 32'hA5A5_0F0F);
    check("wr_reg_be",    r_be,    4'hC);

    // Read, ack 1 cycle after cs: stb-to-ack latency 3.
    run_xfer("read", 1'b0, 6'h0C, 32'h0, 4'hF, 2, -1, 1, 32'h1234_5678);
    check_xfer("rd", 2, 1, 0, 3, 32'h1234_5678);
    check("rd_reg_wr",   r_wr,   0);
    check("rd_reg_addr", r_addr, 4'h3);

    // Zero-wait responder.
    run_xfer("zero_wait", 1'b0, 6'h3C, 32'h0, 4'h1, 1, -1, 1, 32'h0BAD_F00D);
    check_xfer("zw", 1, 1, 0, 2, 32'h0BAD_F00D);
    check("zw_reg_addr", r_addr, 4'hF);

    // stb lingering across RESP and DRAIN edges must not restart a transfer.
    run_xfer("drain", 1'b0, 6'h04, 32'h0, 4'hF, 1, -1, 2, 32'h0000_0042);
    check_xfer("drain", 1, 1, 0, 2, 32'h0000_0042);

    // No responder: cs for 16 cycles, err at 17.
    run_xfer("timeout", 1'b0, 6'h10, 32'h0, 4'hF, -1, -1, 1, 32'h5555_5555);
    exp_to++;
    check_xfer("to", TO, 0, 1, TO + 1, 32'hDEAD_BEEF);
    check("to_tocnt", timeout_cnt, exp_to);

    // Master abandons the cycle; transfer still runs to reg_ack.
    run_xfer("abort", 1'b0, 6'h14, 32'h0, 4'hF, 5, 1, 1, 32'h7777_7777);
    check_xfer("abort", 5, 0, 0, -1, 32'h0);
    check("abort_tocnt", timeout_cnt, exp_to);

    // reg_ack on the final timer cycle wins over the timeout.
    run_xfer("coincide", 1'b0, 6'h18, 32'h0, 4'hF, TO, -1, 1, 32'hCAFE_0001);
    check_xfer("coin", TO, 1, 0, TO + 1, 32'hCAFE_0001);
    check("coin_tocnt", timeout_cnt, exp_to);

    // Stray reg_ack in IDLE is ignored.
    seen_cs = 0; seen_ack = 0; seen_err = 0;
    for (int i = 0; i < 3; i++) begin
      bus.reg_ack = 1'b1;
      tick();
      if (bus.reg_cs)    seen_cs++;
      if (bus.wbs_ack_o) seen_ack++;
      if (bus.wbs_err_o) seen_err++;
    end
    bus.reg_ack = 1'b0;
    check("idle_ack_cs",  seen_cs,  0);
    check("idle_ack_ack", seen_ack, 0);
    check("idle_ack_err", seen_err, 0);
    check("idle_ack_dat", bus.wbs_dat_o, 32'hCAFE_0001);

    // Saturation of the timeout counter.
    for (int i = 0; i < 300; i++) begin
      run_xfer("sat_to", 1'b0, 6'h20, 32'h0, 4'hF, -1, -1, 1, 32'h0);
      if (exp_to != 255) exp_to++;
      check("sat_err_cnt", r_err_cnt, 1);
      if (exp_to == 255 || i == 299) check("sat_tocnt", timeout_cnt, exp_to);
    end
    check("sat_final", timeout_cnt, 8'hFF);

    // Asynchronous reset in the middle of WAIT.
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_adr_i = 6'h24;
    for (int i = 0; i < 4; i++) tick();
    check("mid_cs_before", bus.reg_cs, 1);
    #2;
    h_reset_n = 1'b0;
    #1;
    check("mid_rst_cs",    bus.reg_cs,    0);
    check("mid_rst_tocnt", timeout_cnt,   0);
    check("mid_rst_dat",   bus.wbs_dat_o, 0);
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    tick(); tick();
    @(negedge mclk);
    h_reset_n = 1'b1;
    seen_cs = 0; seen_ack = 0; seen_err = 0;
    for (int i = 0; i < TO + 4; i++) begin
      tick();
      if (bus.reg_cs)    seen_cs++;
      if (bus.wbs_ack_o) seen_ack++;
      if (bus.wbs_err_o) seen_err++;
    end
    check("post_rst_cs",  seen_cs,  0);
    check("post_rst_ack", seen_ack, 0);
    check("post_rst_err", seen_err, 0);

    // Bridge is usable again after reset.
    run_xfer("post_rst", 1'b1, 6'h2C, 32'h0102_0304, 4'h3, 2, -1, 1, 32'h0);
    check_xfer("post", 2, 1, 0, 3, 32'h0);
    check("post_reg_addr", r_addr, 4'hB);
    check("post_reg_be",   r_be,   4'h3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb2reg_bridge.md
Name: wb2reg_bridge

Overview:
- Wishbone-classic slave to register-bus initiator. Drives the reg_cs/reg_wr/reg_addr/reg_wdata/reg_be bus that peripheral register blocks (GPIO, PWM, timers) respond to.
- Converts one Wishbone access into exactly one reg-bus transfer and returns ack, or err on timeout.
- Sits between the system Wishbone interconnect and a single peripheral register block.

Parameters:
- TIMEOUT_CYC, 255, reg_cs cycles without reg_ack before the access is aborted with wbs_err_o (legal 2..65535).
- ERR_RDATA, 32'hDEAD_BEEF, value returned on wbs_dat_o for a timed-out access.

Ports:
- mclk  input  1  system clock
- h_reset_n  input  1  asynchronous active-low reset
- wbs_cyc_i  input  1  Wishbone cycle
- wbs_stb_i  input  1  Wishbone strobe
- wbs_we_i  input  1  1 = write
- wbs_adr_i  input  6  byte address; [5:2] is the word address
- wbs_dat_i  input  32  write data
- wbs_sel_i  input  4  byte selects
- wbs_dat_o  output  32  read data
- wbs_ack_o  output  1  normal completion, one-cycle pulse
- wbs_err_o  output  1  timeout completion, one-cycle pulse
- reg_cs  output  1  register-bus chip select
- reg_wr  output  1  register-bus write
- reg_addr  output  4  register-bus word address
- reg_wdata  output  32  register-bus write data
- reg_be  output  4  register-bus byte enables
- reg_rdata  input  32  register-bus read data
- reg_ack  input  1  register-bus acknowledge
- timeout_cnt  output  8  saturating count of timed-out accesses

Behaviour:
- Reset: async assert; all outputs and registers are 0; state is IDLE.
- All outputs are registered.
- States: IDLE, WAIT, RESP, DRAIN.
- IDLE:
  - On wbs_cyc_i & wbs_stb_i, latch we/adr[5:2]/dat/sel onto reg_wr/reg_addr/reg_wdata/reg_be.
  - Set reg_cs = 1 on the next edge, clear the timer, go to WAIT.
  - reg_ack is ignored in IDLE.
- WAIT:
  - reg_cs and the latched fields are held stable.
  - The timer increments each cycle.
  - On reg_ack = 1:
    - reg_cs = 0 next edge.
    - For a read, capture reg_rdata into wbs_dat_o; for a write, wbs_dat_o = 0.
    - If wbs_cyc_i is still 1, go to RESP with wbs_ack_o = 1. Otherwise go to IDLE with no Wishbone response (aborted cycle).
  - On timer == TIMEOUT_CYC-1 with no reg_ack:
    - reg_cs = 0.
    - wbs_dat_o = ERR_RDATA.
    - wbs_err_o = 1 if cyc is still high.
    - timeout_cnt += 1, saturating at 255.
    - Go to RESP, or to IDLE if cyc is low.
  - reg_ack and timeout in the same cycle: reg_ack wins, normal completion.
  - Dropping wbs_cyc_i mid-WAIT does not drop reg_cs early. The transfer runs to ack or timeout.
- RESP:
  - wbs_ack_o or wbs_err_o is high for exactly this one cycle, then cleared; go to DRAIN.
  - wbs_dat_o is held until the next completion.
- DRAIN:
  - One cycle. Prevents the still-high stb of the completed access from restarting a transfer. Go to IDLE.
  - A back-to-back master that keeps stb high for a new access is accepted in IDLE.
- Latency:
  - stb sampled at cycle 0 → reg_cs at cycle 1.
  - reg_ack at cycle k → wbs_ack_o at cycle k+1.
  - Zero-wait responder (ack at cycle 1) gives a 2-cycle access plus 1 DRAIN cycle.
- reg_ack is never expected outside WAIT. If it occurs, it is ignored with no state change.
- wbs_ack_o and wbs_err_o are never high together.
- Reset mid-WAIT: reg_cs drops asynchronously and no response is issued.

Decomposition:
- Shared package wb2reg_pkg holds:
  - state enum (IDLE, WAIT, RESP, DRAIN), 2 bits;
  - localparam for timer width, $clog2(TIMEOUT_CYC+1);
  - default ERR_RDATA constant.
- No sub-module: the timer and FSM are a single always_ff plus next-state logic.

Test Plan:
- Write wbs_adr_i = 6'h08, dat = 32'hA5A5_0F0F, sel = 4'hC; responder acks 2 cycles after cs → reg_addr = 4'h2, reg_wdata = 32'hA5A5_0F0F, reg_be = 4'hC, reg_wr = 1. wbs_ack_o is a single pulse on the cycle after reg_ack, and reg_cs is high exactly 3 cycles.
- Read adr 6'h0C; responder returns reg_rdata = 32'h1234_5678 with ack 1 cycle after cs → wbs_dat_o = 32'h1234_5678 with wbs_ack_o. Total stb-to-ack latency is 3 cycles.
- Read with no responder, TIMEOUT_CYC = 16 → reg_cs is high for 16 cycles, then wbs_err_o pulses once. wbs_dat_o = 32'hDEAD_BEEF, timeout_cnt = 1, wbs_ack_o never rises.
- Master drops wbs_cyc_i 1 cycle after the request; responder acks 4 cycles later → reg_cs stays high until reg_ack. No wbs_ack_o or wbs_err_o is produced, and the FSM returns to IDLE.
- reg_ack coincident with the timer reaching TIMEOUT_CYC-1 → normal wbs_ack_o with reg_rdata, and timeout_cnt is unchanged.
- 300 consecutive timed-out accesses → timeout_cnt saturates at 8'hFF. Then assert h_reset_n = 0 mid-WAIT → reg_cs = 0 and timeout_cnt = 0 immediately, with no clock edge required.
